// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants, the stage control bundle and a
// configuration check for the pipelined adder.
package pipe_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Control bits that travel alongside each stage's sum slice.
  typedef struct packed {
    logic valid;  // stage holds a live operation
    logic carry;  // carry out of the slice summed in this stage
  } stage_ctl_t;

  // True when the word splits into equal slices and is wide enough to
  // have a sign bit distinct from the bit below it.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage : pipe_adder_pkg

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit ripple adder made of full-adder cells.
// Besides the sum and carry-out it exposes the carry into its MSB, which the
// top-level uses in its final stage to form the signed-overflow flag.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         msb_ci
);

  logic [W:0] c;

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    // NOTE: blocking assignments so each bit sees the carry computed just
    // above it; defaults first so no path leaves c or s unassigned.
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co     = c[W];
  assign msb_ci = c[W-1];

endmodule : adder_slice

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder split into STAGES equal slices, one slice per
// pipeline stage, with the slice carry registered between stages. A global
// stall (out_valid && !out_ready) freezes every stage; in_ready = !stall.
// Optional macro PIPE_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // ---------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;

`ifdef PIPE_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; the forced carry-in overrides ci.
  assign b_eff  = sub ? ~b : b;
  assign ci_eff = sub | ci;
`else
  assign b_eff  = b;
  assign ci_eff = ci;
`endif

  // ---------------------------------------------------------------------
  // Handshake: one stall signal freezes the whole pipe so bubbles keep
  // their position and nothing is lost or duplicated.
  // ---------------------------------------------------------------------
  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------------------------------------------------------------
  // Stages. Stage k consumes the lowest slice of the operand bits still
  // in flight, appends its sum slice above the completed lower slices,
  // and forwards the remaining operand bits (the skew buffer) upward.
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SRC_W  = WIDTH - k * SLICE;  // operand bits still pending
    localparam int DONE_W = (k + 1) * SLICE;    // sum bits complete after k

    logic [SRC_W-1:0]  a_src;
    logic [SRC_W-1:0]  b_src;
    stage_ctl_t        ctl_src;
    logic [SLICE-1:0]  s_slice;
    logic [DONE_W-1:0] s_next;
    logic              c_out;
    logic              c_msb;

    stage_ctl_t        ctl_q;
    logic [DONE_W-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_src   = a;
      assign b_src   = b_eff;
      assign ctl_src = '{valid: in_valid, carry: ci_eff};
      assign s_next  = s_slice;
    end else begin : g_link
      assign a_src   = g_stage[k-1].g_skew.a_q;
      assign b_src   = g_stage[k-1].g_skew.b_q;
      assign ctl_src = g_stage[k-1].ctl_q;
      assign s_next  = {s_slice, g_stage[k-1].s_q};
    end

    adder_slice #(
      .W(SLICE)
    ) u_slice (
      .a      (a_src[SLICE-1:0]),
      .b      (b_src[SLICE-1:0]),
      .ci     (ctl_src.carry),
      .s      (s_slice),
      .co     (c_out),
      .msb_ci (c_msb)
    );

    // Valid bit, slice carry and completed sum bits advance unless stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: data registers are cleared as well as valid bits so sum and
        // co read 0 after reset instead of leftovers from discarded work.
        ctl_q <= '0;
        s_q   <= '0;
      end else if (!stall) begin
        ctl_q <= '{valid: ctl_src.valid, carry: c_out};
        s_q   <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [SRC_W-SLICE-1:0] a_q;
      logic [SRC_W-SLICE-1:0] b_q;
      logic                   unused_c_msb;

      // Only the final slice's MSB carry matters for overflow.
      assign unused_c_msb = c_msb;

      // Operand bits not yet summed ride along to the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_src[SRC_W-1:SLICE];
          b_q <= b_src[SRC_W-1:SLICE];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Signed overflow: carry into the word MSB differs from carry out.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= c_msb ^ c_out;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs come straight from the last stage's registers.
  // ---------------------------------------------------------------------
  assign out_valid = g_stage[STAGES-1].ctl_q.valid;
  assign co        = g_stage[STAGES-1].ctl_q.carry;
  assign sum       = g_stage[STAGES-1].s_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed self-checking bench for pipe_adder with
// WIDTH=16, STAGES=4. Define PIPE_ADDER_SUB_EN to also cover subtraction.
module tb_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-computed streaming vectors: {co, sum} = a + b + ci.
  logic [15:0] op_a  [8] = '{16'h0001, 16'h1234, 16'h8000, 16'hFFFF,
                             16'h4000, 16'h0F0F, 16'hABCD, 16'hC000};
  logic [15:0] op_b  [8] = '{16'h0001, 16'h1111, 16'h8000, 16'hFFFF,
                             16'h4000, 16'h00F1, 16'h1111, 16'hC000};
  logic        op_ci [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] ex_s  [8] = '{16'h0002, 16'h2346, 16'h0000, 16'hFFFF,
                             16'h8000, 16'h1000, 16'hBCDE, 16'h8001};
  logic        ex_co [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        ex_ov [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  // Per-cycle schedule for the stream/stall step (-1 = none).
  int   sch_in  [16] = '{0, 1, 2, 3, 4, 5, 6, 6, 6, 6, 7, -1, -1, -1, -1, -1};
  logic sch_or  [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                         1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int   sch_out [16] = '{-1, -1, -1, -1, 0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, -1};
  logic sch_ir  [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                         1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef PIPE_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] av,
                       input logic [15:0] bv, input logic cv);
    in_valid = v;
    a        = av;
    b        = bv;
    ci       = cv;
  endtask

  task automatic check_out(input string tag, input logic v,
                           input logic [15:0] s, input logic c,
                           input logic o);
    check({tag, "_valid"}, out_valid, v);
    if (v) begin
      check({tag, "_sum"}, sum, s);
      check({tag, "_co"},  co,  c);
      check({tag, "_ovf"}, ovf, o);
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();

    // Reset held while an input is offered: the input must be dropped.
    drive(1'b1, 16'h0001, 16'h0001, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_sum",       sum,       16'h0000);
    check("rst_co",        co,        1'b0);
    check("rst_ovf",       ovf,       1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("rst_drop_input", out_valid, 1'b0);
    end
    tick();

    // Basic add with latency: valid appears exactly STAGES cycles later.
    drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    check("basic_in_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 1; i < STAGES; i++) begin
      @(negedge clk);
      check("basic_latency", out_valid, 1'b0);
      tick();
    end
    @(negedge clk);
    check_out("basic", 1'b1, 16'h0100, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check("basic_single", out_valid, 1'b0);
    tick();

    // Full carry ripple then signed overflow, back to back.
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    tick();
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    tick();
    @(negedge clk);
    check_out("ripple", 1'b1, 16'h0000, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    check_out("sovf", 1'b1, 16'h8000, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    check("pair_end", out_valid, 1'b0);
    tick();

    // Stream 8 ops; out_ready low for 3 cycles starting at cycle 6.
    for (int c = 0; c < 16; c++) begin
      if (sch_in[c] >= 0)
        drive(1'b1, op_a[sch_in[c]], op_b[sch_in[c]], op_ci[sch_in[c]]);
      else
        drive(1'b0, 16'h0000, 16'h0000, 1'b0);
      out_ready = sch_or[c];
      @(negedge clk);
      check("stream_in_ready", in_ready, sch_ir[c]);
      if (sch_out[c] >= 0)
        check_out("stream", 1'b1, ex_s[sch_out[c]], ex_co[sch_out[c]],
                  ex_ov[sch_out[c]]);
      else
        check_out("stream_idle", 1'b0, 16'h0000, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;

    // Reset with three ops in flight: none of them may ever appear.
    drive(1'b1, op_a[1], op_b[1], op_ci[1]);
    tick();
    drive(1'b1, op_a[3], op_b[3], op_ci[3]);
    tick();
    drive(1'b1, op_a[5], op_b[5], op_ci[5]);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum",       sum,       16'h0000);
    check("midrst_co",        co,        1'b0);
    check("midrst_in_ready",  in_ready,  1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      check("midrst_never_emitted", out_valid, 1'b0);
    end
    tick();

`ifdef PIPE_ADDER_SUB_EN
    // Subtract mode: ci is ignored, co=0 signals a borrow.
    sub = 1'b1;
    drive(1'b1, 16'h0005, 16'h0007, 1'b0);
    tick();
    drive(1'b1, 16'h8000, 16'h0001, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    sub = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_out("sub_borrow", 1'b1, 16'hFFFE, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    check_out("sub_ovf", 1'b1, 16'h7FFF, 1'b1, 1'b1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipe_adder

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined WIDTH-bit adder with carry-in, carry-out and signed-overflow flag. It is the multi-bit, clocked successor to the single-bit full adder cell. The operand word is split into STAGES equal slices, and one slice is added per pipeline stage, with the carry registered between stages. A valid/ready handshake on both sides lets it sit inside streaming datapaths and accept one operation per cycle.

## Interface
- WIDTH, 16: operand and sum width in bits; must be ≥ 2.
- STAGES, 4: pipeline depth and slice count; WIDTH % STAGES == 0 required; SLICE = WIDTH/STAGES.

Ports (clock and reset first):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a, b, ci (and sub) are valid this cycle.
- in_ready  out  1  the block accepts the input this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in into bit 0.
- out_valid  out  1  sum, co and ovf are valid.
- out_ready  in  1  the downstream consumer accepts the result.
- sum  out  WIDTH  result bits.
- co  out  1  carry out of the MSB.
- ovf  out  1  signed overflow: the carries into and out of the MSB differ.

## Operation
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Global stall: stall = out_valid && !out_ready. While stall is 1, every stage register holds its value.
- in_ready = !stall. This is combinational from out_valid and out_ready; there is no combinational path from in_valid.
- Stage k (0..STAGES-1):
  - Adds operand slice k (bits k·SLICE+SLICE-1 .. k·SLICE) plus the carry registered from stage k-1.
  - Stage 0 uses ci as its carry.
- Skew buffers:
  - Upper operand slices are delayed so that each slice meets its carry at the correct stage.
  - Completed lower sum slices are delayed so that all sum bits leave together.
- Per-stage valid bit: when not stalled, valid[0] <= in_valid and valid[k] <= valid[k-1]; out_valid = valid[STAGES-1].
- Bubbles:
  - Data registers of invalid stages may update, but their contents are don't-care.
  - Valid bits shift through, so bubbles are preserved in order and never collapse.
- Arithmetic: {co, sum} = a + b + ci, computed exactly on WIDTH+1 bits, with no truncation other than into co.
- ovf is computed in the last stage as (carry into bit WIDTH-1) XOR co.
- Reset:
  - All valid bits clear, out_valid=0, in_ready=1.
  - sum=0, co=0, ovf=0, and all stage data registers clear.
  - Operations in flight are discarded and are never emitted.
  - The result register updates only when not stalled, so results are held stable across stalls.

## Timing
- Latency: STAGES cycles from the input transfer to out_valid, assuming no stalls.
  - STAGES=1 means the result is registered once.
- Throughput: one operation per cycle when out_ready is held at 1.
- Output stall with in_valid=1: in_ready=0 in the same cycle and no input is consumed. The pipeline resumes in the cycle after out_ready rises.
- Simultaneous output and input transfer on a full pipeline is allowed; no bubble is inserted.
- Reset asserted in the same cycle as in_valid: reset wins and the input is dropped.
- After reset deasserts, in_ready=1 in the first cycle.

## Configuration
- PIPE_ADDER_SUB_EN:
  - When defined, adds input port sub (1 bit), which travels with the operands.
  - When sub=1, the block computes a − b: stage 0 uses ~b with a forced carry-in of 1, and ci is ignored.
  - In subtract mode, co=1 means no borrow and ovf is signed subtraction overflow.
  - When undefined, the port is absent and the block only adds.

## Structure
- Package pipe_adder_pkg contains:
  - a localparam function checking WIDTH % STAGES == 0;
  - default parameter constants;
  - a typedef for the stage carry/valid bundle.
- Sub-module adder_slice: a combinational SLICE-bit ripple adder built from full-adder cells, with outputs s, co and the MSB carry-in (used for ovf). It is instantiated once per stage.
- The top level holds the registers, skew buffers and handshake logic only.

## Test plan
- Basic add, WIDTH=16, STAGES=4, out_ready=1: a=0x00FF, b=0x0001, ci=0 → after 4 cycles sum=0x0100, co=0, ovf=0.
- Full carry ripple across all slices: a=0xFFFF, b=0x0000, ci=1 → sum=0x0000, co=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, ci=0 → sum=0x8000, co=0, ovf=1.
- Back-to-back and stall:
  - Stream 8 ops, one per cycle; drop out_ready for 3 cycles at cycle 6.
  - Expected: results appear in order, held stable during the stall, in_ready=0 during the stall, and no op is lost or duplicated.
- Reset mid-stream: assert rst while 3 ops are in flight → out_valid=0 the next cycle, none of the 3 is ever emitted, and sum=0.
- With PIPE_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, co=0 (borrow); a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1.
